// File: rtl/fifo_rd_ctrl.sv
// Read-side pointer and flag controller for the dual-clock FIFO.
// Synchronises the Gray write pointer, tracks the read pointer, and derives empty/level flags.
module fifo_rd_ctrl #(
    parameter int DEPTH     = 32,
    parameter int AW        = $clog2(DEPTH),
    parameter int AE_THRESH = 2,
    parameter int DW        = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW:0]   wr_ptr_gray,
    input  logic          rd_en,
    input  logic [DW-1:0] ram_rd_data,
    output logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic [AW:0]   rd_ptr_gray,
    output logic          empty,
    output logic          almost_empty,
    output logic [AW:0]   level,
    output logic          underflow
);

    localparam int PW = AW + 1;

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0] wr_gray_p1;
    logic [PW-1:0] wr_gray_p2;
    logic [PW-1:0] rd_bin;
    logic [PW-1:0] wr_bin_s;
    logic [PW-1:0] rd_bin_next;
    logic [PW-1:0] rd_gray_next;
    logic [PW-1:0] avail;
    logic          rd_fire;

    assign wr_bin_s     = gray2bin(wr_gray_p2);
    assign rd_fire      = rd_en & ~empty;
    assign rd_bin_next  = rd_bin + PW'(rd_fire);
    assign rd_gray_next = bin2gray(rd_bin_next);
    // Modulo subtraction yields DEPTH when full thanks to the extra pointer bit.
    assign avail        = wr_bin_s - rd_bin_next;

    assign rd_addr = rd_bin[AW-1:0];
    assign rd_data = ram_rd_data;

    // Stage p1/p2: two-flop synchroniser for the foreign-domain Gray pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_gray_p1 <= '0;
            wr_gray_p2 <= '0;
        end else begin
            wr_gray_p1 <= wr_ptr_gray;
            wr_gray_p2 <= wr_gray_p1;
        end
    end

    // Read pointer, flags and read-valid strobe all register against the next pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_bin       <= '0;
            rd_ptr_gray  <= '0;
            rd_valid     <= 1'b0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            level        <= '0;
            underflow    <= 1'b0;
        end else begin
            rd_bin       <= rd_bin_next;
            rd_ptr_gray  <= rd_gray_next;
            rd_valid     <= rd_fire;
            empty        <= (rd_gray_next == wr_gray_p2);
            almost_empty <= (avail <= PW'(AE_THRESH));
            level        <= avail;
            if (rd_en && empty) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Randomised scoreboard bench for fifo_rd_ctrl against a counter-level FIFO model.
module tb_fifo_rd_ctrl;

    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int PW    = AW + 1;
    localparam int AE    = 2;
    localparam int DW    = 8;
    localparam int MOD   = 2 * DEPTH;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [PW-1:0] wr_ptr_gray = '0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] ram_rd_data = '0;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [PW-1:0] rd_ptr_gray;
    logic          empty;
    logic          almost_empty;
    logic [PW-1:0] level;
    logic          underflow;

    fifo_rd_ctrl #(.DEPTH(DEPTH), .AE_THRESH(AE), .DW(DW)) dut (
        .clk(clk), .rst(rst), .wr_ptr_gray(wr_ptr_gray), .rd_en(rd_en),
        .ram_rd_data(ram_rd_data), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_valid(rd_valid), .rd_ptr_gray(rd_ptr_gray), .empty(empty),
        .almost_empty(almost_empty), .level(level), .underflow(underflow)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) ram_rd_data <= mem[rd_addr];

    function automatic logic [PW-1:0] to_gray(input int b);
        logic [PW-1:0] v;
        v = PW'(b);
        return v ^ (v >> 1);
    endfunction

    int  wr_bin = 0;
    bit  done = 1'b0;

    // Reference model: counts of words written (as seen after two edges) and words read
    int            m_rd, s1, s2, m_level, m_nxt, m_avail;
    bit            m_empty, m_ae, m_uf, m_vld, m_fire;
    logic [DW-1:0] expq [$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_rd = 0; s1 = 0; s2 = 0; m_level = 0;
            m_empty = 1'b1; m_ae = 1'b1; m_uf = 1'b0; m_vld = 1'b0;
        end else begin
            m_fire = rd_en && !m_empty;
            if (m_fire) expq.push_back(mem[AW'(m_rd)]);
            if (rd_en && m_empty) m_uf = 1'b1;
            m_nxt   = (m_rd + int'(m_fire)) % MOD;
            m_avail = (s2 - m_nxt + MOD) % MOD;
            m_empty = (m_avail == 0);
            m_ae    = (m_avail <= AE);
            m_level = m_avail;
            s2 = s1;
            s1 = wr_bin;
            m_rd  = m_nxt;
            m_vld = m_fire;
        end
    end

    int            checks = 0;
    int            failures = 0;
    int            idx = 0;
    logic [PW-1:0] prev_gray = '0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_empty", int'(empty), 1);
            chk("rst_almost_empty", int'(almost_empty), 1);
            chk("rst_level", int'(level), 0);
            chk("rst_rd_valid", int'(rd_valid), 0);
            chk("rst_rd_ptr_gray", int'(rd_ptr_gray), 0);
            chk("rst_underflow", int'(underflow), 0);
            chk("rst_rd_addr", int'(rd_addr), 0);
            idx = expq.size();
            prev_gray = '0;
        end else begin
            chk("rd_valid", int'(rd_valid), int'(m_vld));
            if (rd_valid) begin
                chk("sb_pending", int'(idx < expq.size()), 1);
                if (idx < expq.size()) begin
                    chk("rd_data", int'(rd_data), int'(expq[idx]));
                    idx++;
                end
            end
            chk("empty", int'(empty), int'(m_empty));
            chk("almost_empty", int'(almost_empty), int'(m_ae));
            chk("level", int'(level), m_level);
            chk("underflow", int'(underflow), int'(m_uf));
            chk("rd_addr", int'(rd_addr), m_rd % DEPTH);
            chk("rd_ptr_gray", int'(rd_ptr_gray), int'(to_gray(m_rd)));
            chk("gray_step", int'($countones(prev_gray ^ rd_ptr_gray) <= 1), 1);
            prev_gray = rd_ptr_gray;
        end
        if (done) begin
            chk("sb_drained", idx, expq.size());
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    task automatic adv_wr();
        mem[AW'(wr_bin)] = DW'($urandom);
        wr_bin      = (wr_bin + 1) % MOD;
        wr_ptr_gray = to_gray(wr_bin);
    endtask

    function automatic int occupancy();
        return (wr_bin - m_rd + MOD) % MOD;
    endfunction

    initial begin
        int slot;
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        repeat (4) @(negedge clk);

        // Gray steps 0->1->3->2, then drain three words plus one underflowing request
        for (int i = 0; i < 3; i++) begin
            adv_wr();
            @(negedge clk);
        end
        repeat (5) @(negedge clk);
        rd_en = 1'b1;
        repeat (4) @(negedge clk);
        rd_en = 1'b0;
        repeat (2) @(negedge clk);

        // Random traffic: read-heavy then write-heavy, wrapping the pointers many times
        for (int c = 0; c < 1500; c++) begin
            rd_en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) != 0 && occupancy() < DEPTH) adv_wr();
            @(negedge clk);
        end
        for (int c = 0; c < 1500; c++) begin
            rd_en = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) != 0 && occupancy() < DEPTH) adv_wr();
            @(negedge clk);
        end

        // Fill to DEPTH, then pop while the write pointer advances in the same cycle
        rd_en = 1'b0;
        for (int k = 0; k <= DEPTH && occupancy() < DEPTH; k++) begin
            adv_wr();
            @(negedge clk);
        end
        repeat (5) @(negedge clk);
        slot        = wr_bin;
        rd_en       = 1'b1;
        wr_bin      = (wr_bin + 1) % MOD;
        wr_ptr_gray = to_gray(wr_bin);
        @(negedge clk);
        rd_en = 1'b0;
        mem[AW'(slot)] = DW'($urandom);
        repeat (5) @(negedge clk);

        // Drain to five entries and reset with a read in flight
        rd_en = 1'b1;
        for (int k = 0; k < 2 * DEPTH && m_level > 5; k++) @(negedge clk);
        @(negedge clk);
        #2;
        rst         = 1'b1;
        rd_en       = 1'b0;
        wr_bin      = 0;
        wr_ptr_gray = '0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            adv_wr();
            @(negedge clk);
        end
        repeat (5) @(negedge clk);
        rd_en = 1'b1;
        repeat (2) @(negedge clk);
        rd_en = 1'b0;
        repeat (4) @(negedge clk);
        done = 1'b1;
    end

endmodule
